// File: rtl/touch_pen_debounce.sv
// touch_pen_debounce: synchronise and debounce the LT24 active-low pen line, with strobes and glitch counter.
// Optional PEN_AUTOREPEAT_EN adds a periodic 2-cycle high pulse on the output while the pen is held.
module touch_pen_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pen_irq_n_in,
  input  logic       glitch_clr,
  output logic       pen_irq_n_out,
  output logic       pen_is_down,
  output logic       pen_down,
  output logic       pen_up,
  output logic       pen_repeat,
  output logic [7:0] glitch_count
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || (2 ** CNT_W) <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("touch_pen_debounce: illegal parameter combination");
  end
`ifdef PEN_AUTOREPEAT_EN
  typedef enum logic [2:0] {UP, DOWN_PEND, DOWN, UP_PEND, REPEAT} state_t;
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt;
`else
  typedef enum logic [1:0] {UP, DOWN_PEND, DOWN, UP_PEND} state_t;
`endif
  state_t state, nxt;
  logic s1, pen_s, glitch, rep_nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    glitch = 1'b0;
    case (state)
      UP: if (!pen_s) begin nxt = DOWN_PEND; cnt_n = '0; end
      DOWN_PEND:
        if (pen_s) begin nxt = UP; glitch = 1'b1; end
        else if (cnt == LAST) nxt = DOWN;
        else cnt_n = cnt + 1'b1;
      DOWN:
        if (pen_s) begin nxt = UP_PEND; cnt_n = '0; end
`ifdef PEN_AUTOREPEAT_EN
        else if (rcnt == RLAST) nxt = REPEAT;
      REPEAT: if (rcnt == RW'(1)) nxt = DOWN;
`endif
      UP_PEND:
        if (!pen_s) begin nxt = DOWN; glitch = 1'b1; end
        else if (cnt == LAST) nxt = UP;
        else cnt_n = cnt + 1'b1;
      default: nxt = UP;
    endcase
  end
`ifdef PEN_AUTOREPEAT_EN
  // rcnt times DOWN residency and then the 2-cycle REPEAT pulse; any state change restarts it
  assign rep_nxt = nxt == REPEAT;
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      pen_repeat <= 1'b0;
    end else begin
      rcnt <= (nxt != state || !(state == DOWN || state == REPEAT)) ? '0 : rcnt + 1'b1;
      pen_repeat <= state == DOWN && nxt == REPEAT;
    end
  end
`else
  assign rep_nxt = 1'b0;
  assign pen_repeat = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      pen_s <= 1'b1;
      state <= UP;
      cnt <= '0;
      glitch_count <= '0;
      pen_irq_n_out <= 1'b1;
      pen_is_down <= 1'b0;
      pen_down <= 1'b0;
      pen_up <= 1'b0;
    end else begin
      s1 <= pen_irq_n_in;
      pen_s <= s1;
      state <= nxt;
      cnt <= cnt_n;
      glitch_count <= glitch_clr ? '0 : (glitch && glitch_count != 8'hff) ? glitch_count + 8'd1 : glitch_count;
      pen_irq_n_out <= !(nxt == DOWN || nxt == UP_PEND);
      pen_is_down <= nxt == DOWN || nxt == UP_PEND || rep_nxt;
      pen_down <= state == DOWN_PEND && nxt == DOWN;
      pen_up <= state == UP_PEND && nxt == UP;
    end
  end
endmodule
